pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program counter unit: selects the next PC from branch, jump and register-jump
// controls, traps misaligned redirects to a fixed exception vector and counts
// committed redirects with a saturating counter.
module pc_unit #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_PC     = 32'h0000_4180,
    parameter int unsigned      DELAY_SLOT = 0,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       br_type,
    input  logic [1:0]       jmp_type,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [15:0]      imm16,
    input  logic [25:0]      index26,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc4,
    output logic [WIDTH-1:0] link,
    output logic             taken,
    output logic             addr_err,
    output logic [CNT_W-1:0] taken_cnt
);

    // Branch condition encodings
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLEZ = 3'b011;
    localparam logic [2:0] BR_BGTZ = 3'b100;
    localparam logic [2:0] BR_BLTZ = 3'b101;
    localparam logic [2:0] BR_BGEZ = 3'b110;

    // Jump encodings
    localparam logic [1:0] JMP_J  = 2'b01;
    localparam logic [1:0] JMP_JR = 2'b10;

    localparam int unsigned    SEXT_W  = WIDTH - 18;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             addr_err_q, addr_err_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic [WIDTH-1:0] pc4_c;
    logic [WIDTH-1:0] pc8_c;
    logic [WIDTH-1:0] br_off_c;
    logic [WIDTH-1:0] br_target_c;
    logic [WIDTH-1:0] j_target_c;
    logic             rs_zero_c;
    logic             rs_neg_c;
    logic             br_cond_c;
    logic             sel_jr_c;
    logic             sel_j_c;
    logic             taken_c;
    logic [WIDTH-1:0] next_pc_c;
    logic             misaligned_c;

    // Sequential-address and redirect-target arithmetic, all modulo 2^WIDTH
    always_comb begin
        pc4_c       = pc_q + WIDTH'(4);
        pc8_c       = pc_q + WIDTH'(8);
        br_off_c    = {{SEXT_W{imm16[15]}}, imm16, 2'b00};
        br_target_c = pc4_c + br_off_c;
        j_target_c  = {pc4_c[WIDTH-1:28], index26, 2'b00};
    end

    // Branch condition evaluation; reserved encodings never branch
    always_comb begin
        rs_zero_c = (rs_val == '0);
        rs_neg_c  = rs_val[WIDTH-1];
        br_cond_c = 1'b0;
        case (br_type)
            BR_BEQ:  br_cond_c = (rs_val == rt_val);
            BR_BNE:  br_cond_c = (rs_val != rt_val);
            BR_BLEZ: br_cond_c = rs_neg_c | rs_zero_c;
            BR_BGTZ: br_cond_c = ~rs_neg_c & ~rs_zero_c;
            BR_BLTZ: br_cond_c = rs_neg_c;
            BR_BGEZ: br_cond_c = ~rs_neg_c;
            default: br_cond_c = 1'b0;
        endcase
    end

    // Next-PC select: register jump beats direct jump beats taken branch
    always_comb begin
        sel_jr_c  = (jmp_type == JMP_JR);
        sel_j_c   = (jmp_type == JMP_J);
        taken_c   = sel_jr_c | sel_j_c | br_cond_c;
        next_pc_c = pc4_c;
        if (sel_jr_c) begin
            next_pc_c = rs_val;
        end else if (sel_j_c) begin
            next_pc_c = j_target_c;
        end else if (br_cond_c) begin
            next_pc_c = br_target_c;
        end
        // Only a register target can carry low bits; pc4 and computed targets are word aligned
        misaligned_c = (next_pc_c[1:0] != 2'b00);
    end

    // Next-state for PC, sticky error flag and saturating redirect counter
    always_comb begin
        pc_d        = pc_q;
        addr_err_d  = addr_err_q;
        taken_cnt_d = taken_cnt_q;
        if (!stall) begin
            if (misaligned_c) begin
                pc_d       = EXC_PC;
                addr_err_d = 1'b1;
            end else begin
                pc_d = next_pc_c;
            end
            if (taken_c && (taken_cnt_q != CNT_MAX)) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset overrides stall and any redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            addr_err_q  <= 1'b0;
            taken_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            addr_err_q  <= addr_err_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign pc        = pc_q;
    assign pc4       = pc4_c;
    assign link      = (DELAY_SLOT != 0) ? pc8_c : pc4_c;
    assign taken     = taken_c;
    assign addr_err  = addr_err_q;
    assign taken_cnt = taken_cnt_q;

endmodule
